// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg
// Shared types for the clock-gate controller: the per-channel state enum,
// the wake-grant index type and the WAKE-phase counter type.
// Optional feature macro: CG_AUTO_IDLE_EN. When it is defined, the IDLE
// state exists. When it is not defined, the enum has only OFF/WAKE/ON.
// No ports (package only).

package clk_gate_pkg;

    // Largest supported channel count. The grant index must be able to hold 0..MAX_CH-1.
    localparam int MAX_CH     = 16;
    localparam int CH_IDX_W   = 4;

    // Wide enough for WAKE_CYCLES up to 15.
    localparam int WAKE_CNT_W = 4;

    typedef logic [CH_IDX_W-1:0]   chIdx_t;
    typedef logic [WAKE_CNT_W-1:0] wakeCnt_t;

`ifdef CG_AUTO_IDLE_EN
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } chState_t;
`else
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2
    } chState_t;
`endif

    // The gate cell is enabled while the channel is waking or running.
    function automatic logic isClockOn(input chState_t s);
        return (s == ST_WAKE) || (s == ST_ON);
    endfunction

endpackage

// File: rtl/clk_gate_arb.sv
// clk_gate_arb
// Round-robin wake arbiter. It issues at most one wake grant per cycle, and only
// when no channel is currently in WAKE. This keeps at most one channel in
// WAKE at any time. The search starts at the channel after the last one
// granted. After reset, the last-granted pointer is NUM_CH-1, so channel 0
// has the highest priority.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   wake_req_i   per-channel "would like to enter WAKE" flags
//   wake_busy_i  some channel is currently in WAKE
//   grant_o      one-hot (or zero) wake grant, combinational

module clk_gate_arb
    import clk_gate_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] wake_req_i,
    input  logic              wake_busy_i,
    output logic [NUM_CH-1:0] grant_o
);

    chIdx_t lastGrant_q;
    chIdx_t lastGrant_d;
    logic   found;

    // Returns the channel that has priority level k, counted from just after the last grant.
    function automatic int rrIndex(input chIdx_t last, input int k);
        return (int'(last) + 1 + k) % NUM_CH;
    endfunction

    // Scan the priority levels in order and grant the first requester.
    // Both loops are constant-bounded, so every index stays a constant.
    always_comb begin
        grant_o     = '0;
        lastGrant_d = lastGrant_q;
        found       = 1'b0;
        if (!wake_busy_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!found && wake_req_i[i] && (rrIndex(lastGrant_q, k) == i)) begin
                        grant_o[i]  = 1'b1;
                        lastGrant_d = chIdx_t'(i);
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    // Remember the last granted channel so that the next search starts just after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lastGrant_q <= chIdx_t'(NUM_CH - 1);
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/clk_gate_ch.sv
// clk_gate_ch
// Clock-gating FSM for one channel: OFF -> WAKE -> ON (-> IDLE).
// WAKE lasts exactly WAKE_CYCLES cycles. The outputs are registered copies
// of the state decode, so no input reaches an output combinationally.
// Optional feature macro: CG_AUTO_IDLE_EN. When it is defined, an idle counter
// moves the channel from ON to IDLE after idle_limit_i consecutive
// not-busy cycles. When it is not defined, busy_i and idle_limit_i are
// ignored.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   req_i         clock request (level)
//   force_on_i    override that keeps the clock on
//   busy_i        activity / wake sense
//   idle_limit_i  idle cycles before auto-gating (0 disables auto-gating)
//   grant_i       wake grant from the arbiter
//   wake_req_o    this channel wants to enter WAKE
//   in_wake_o     this channel is in WAKE
//   cg_en_o       gate-cell enable (WAKE or ON)
//   ack_o         clock running and stable (ON)

module clk_gate_ch
    import clk_gate_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              force_on_i,
    input  logic              busy_i,
    input  logic [IDLE_W-1:0] idle_limit_i,
    input  logic              grant_i,
    output logic              wake_req_o,
    output logic              in_wake_o,
    output logic              cg_en_o,
    output logic              ack_o
);

    chState_t state_q, state_d;
    wakeCnt_t wakeCnt_q, wakeCnt_d;
    logic     cgEn_q, ack_q;
    logic     keepOn;

    assign keepOn = req_i | force_on_i;

`ifdef CG_AUTO_IDLE_EN
    logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;
    logic [IDLE_W-1:0] idleInc;

    // The idle count saturates at its maximum, so it can never wrap back below the limit.
    assign idleInc = (idleCnt_q == '1) ? idleCnt_q
                                       : idleCnt_q + {{(IDLE_W-1){1'b0}}, 1'b1};

    // An IDLE channel asks to wake only while it still has a reason to stay
    // powered and the fabric signals activity.
    assign wake_req_o = keepOn && (((state_q == ST_OFF)) ||
                                   ((state_q == ST_IDLE) && (busy_i || force_on_i)));
`else
    logic unusedIdleInputs;
    assign unusedIdleInputs = ^{busy_i, idle_limit_i};
    assign wake_req_o       = keepOn && (state_q == ST_OFF);
`endif

    assign in_wake_o = (state_q == ST_WAKE);
    assign cg_en_o   = cgEn_q;
    assign ack_o     = ack_q;

    // Next-state logic. Once WAKE is entered it always runs to ON, even if the
    // request drops. The ON state then drops to OFF one cycle later.
    always_comb begin
        state_d   = state_q;
        wakeCnt_d = wakeCnt_q;
`ifdef CG_AUTO_IDLE_EN
        idleCnt_d = idleCnt_q;
`endif
        case (state_q)
            ST_OFF: begin
                if (keepOn && grant_i) begin
                    state_d   = ST_WAKE;
                    wakeCnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wakeCnt_q == wakeCnt_t'(WAKE_CYCLES - 1)) begin
                    state_d   = ST_ON;
                    wakeCnt_d = '0;
                end else begin
                    wakeCnt_d = wakeCnt_q + wakeCnt_t'(1);
                end
            end
            ST_ON: begin
                if (!keepOn) begin
                    state_d = ST_OFF;
`ifdef CG_AUTO_IDLE_EN
                end else if (force_on_i || (idle_limit_i == '0) || busy_i) begin
                    idleCnt_d = '0;
                end else begin
                    idleCnt_d = idleInc;
                    if (idleInc >= idle_limit_i) begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
`ifdef CG_AUTO_IDLE_EN
            ST_IDLE: begin
                if (!keepOn) begin
                    state_d = ST_OFF;
                end else if (grant_i) begin
                    state_d   = ST_WAKE;
                    wakeCnt_d = '0;
                end
            end
`endif
            default: state_d = ST_OFF;
        endcase
`ifdef CG_AUTO_IDLE_EN
        if (state_d != ST_ON) begin
            idleCnt_d = '0;
        end
`endif
    end

    // State and counter registers. The outputs are registered from the next
    // state, so they always match the decode of the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            wakeCnt_q <= '0;
            cgEn_q    <= 1'b0;
            ack_q     <= 1'b0;
`ifdef CG_AUTO_IDLE_EN
            idleCnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wakeCnt_q <= wakeCnt_d;
            cgEn_q    <= isClockOn(state_d);
            ack_q     <= (state_d == ST_ON);
`ifdef CG_AUTO_IDLE_EN
            idleCnt_q <= idleCnt_d;
`endif
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
// Top level of the clock-gate controller. It contains NUM_CH per-channel
// FSMs that share one round-robin wake arbiter. The arbiter allows only
// one channel to wake at a time.
// Optional feature macro: CG_AUTO_IDLE_EN (auto-gating of idle channels).
// Ports:
//   clk           system clock (rising edge)
//   rst_n         synchronous active-low reset
//   req_i         per-channel clock request
//   force_on_i    per-channel keep-on override
//   busy_i        per-channel activity / wake sense
//   idle_limit_i  idle cycles before auto-gating (0 disables auto-gating)
//   cg_en_o       per-channel gate-cell enable
//   ack_o         per-channel clock-running acknowledge

module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] force_on_i,
    input  logic [NUM_CH-1:0] busy_i,
    input  logic [IDLE_W-1:0] idle_limit_i,
    output logic [NUM_CH-1:0] cg_en_o,
    output logic [NUM_CH-1:0] ack_o
);

    logic [NUM_CH-1:0] wakeReq;
    logic [NUM_CH-1:0] inWake;
    logic [NUM_CH-1:0] grant;
    logic              wakeBusy;

    assign wakeBusy = |inWake;

    clk_gate_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .wake_req_i  (wakeReq),
        .wake_busy_i (wakeBusy),
        .grant_o     (grant)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_gate_ch #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_W      (IDLE_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_i        (req_i[g]),
            .force_on_i   (force_on_i[g]),
            .busy_i       (busy_i[g]),
            .idle_limit_i (idle_limit_i),
            .grant_i      (grant[g]),
            .wake_req_o   (wakeReq[g]),
            .in_wake_o    (inWake[g]),
            .cg_en_o      (cg_en_o[g]),
            .ack_o        (ack_o[g])
        );
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl
// Directed testbench for clk_gate_ctrl (NUM_CH=4, WAKE_CYCLES=2, IDLE_W=8).
// The expected values are worked out by hand for each cycle. Inputs are
// driven 1 ns after each rising edge, and the outputs are sampled at that
// same point. When CG_AUTO_IDLE_EN is defined, the auto-idle scenario is
// exercised. Otherwise the bench checks that busy_i is ignored.

module tb_clk_gate_ctrl;

    localparam int NUM_CH      = 4;
    localparam int WAKE_CYCLES = 2;
    localparam int IDLE_W      = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] req_i;
    logic [NUM_CH-1:0] force_on_i;
    logic [NUM_CH-1:0] busy_i;
    logic [IDLE_W-1:0] idle_limit_i;
    logic [NUM_CH-1:0] cg_en_o;
    logic [NUM_CH-1:0] ack_o;

    int testsRun    = 0;
    int testsFailed = 0;

    // Expected outputs per cycle after req_i=4'b1111 arrives from reset.
    logic [3:0] allCg  [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011,
                                4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    logic [3:0] allAck [12] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0011,
                                4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b0111, 4'b1111};

    clk_gate_ctrl #(
        .NUM_CH      (NUM_CH),
        .WAKE_CYCLES (WAKE_CYCLES),
        .IDLE_W      (IDLE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .force_on_i   (force_on_i),
        .busy_i       (busy_i),
        .idle_limit_i (idle_limit_i),
        .cg_en_o      (cg_en_o),
        .ack_o        (ack_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] frc,
                                 input logic [3:0] busy, input logic [7:0] limit);
        req_i        = req;
        force_on_i   = frc;
        busy_i       = busy;
        idle_limit_i = limit;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPins(input string tag, input logic [3:0] expCg, input logic [3:0] expAck);
        checkOutput({tag, ".cg"}, 32'(cg_en_o), 32'(expCg));
        checkOutput({tag, ".ack"}, 32'(ack_o), 32'(expAck));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 8'd0);

        // Reset state.
        doReset();
        checkPins("reset", 4'b0000, 4'b0000);

        // A single request: enable one cycle later, ack three cycles later.
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 8'd0);
        tick(); checkPins("single.c1", 4'b0001, 4'b0000);
        tick(); checkPins("single.c2", 4'b0001, 4'b0000);
        tick(); checkPins("single.c3", 4'b0001, 4'b0001);

        // Dropping the request while ON gates the clock the next cycle.
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 8'd0);
        tick(); checkPins("drop.on", 4'b0000, 4'b0000);

        // Dropping the request mid-WAKE still completes to ON, then goes OFF.
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 8'd0);
        tick(); checkPins("midwake.c1", 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 8'd0);
        tick(); checkPins("midwake.c2", 4'b0001, 4'b0000);
        tick(); checkPins("midwake.on", 4'b0001, 4'b0001);
        tick(); checkPins("midwake.off", 4'b0000, 4'b0000);

        // All four channels request at once and wake in order 0..3, one at a time.
        doReset();
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 8'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            checkPins($sformatf("all.c%0d", c + 1), allCg[c], allAck[c]);
            checkOutput($sformatf("all.oneWake.c%0d", c + 1),
                        32'($countones(cg_en_o & ~ack_o) <= 1), 32'd1);
        end

        // Round robin: after channel 2 is granted, channel 3 comes before 0 and 1.
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 8'd0);
        tick(); checkPins("rr.alloff", 4'b0000, 4'b0000);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 8'd0);
        tick(); tick(); tick();
        checkPins("rr.ch2on", 4'b0100, 4'b0100);
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 8'd0);
        tick(); checkPins("rr.ch3wake", 4'b1100, 4'b0100);
        tick(); tick(); checkPins("rr.ch3on", 4'b1100, 4'b1100);
        tick(); checkPins("rr.ch0wake", 4'b1101, 4'b1100);

        // The force override alone wakes a channel.
        doReset();
        applyStimulus(4'b0000, 4'b1000, 4'b0000, 8'd0);
        tick(); tick(); tick();
        checkPins("force.on", 4'b1000, 4'b1000);

        // Reset during the WAKE of channel 2 abandons it with no further output.
        doReset();
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 8'd0);
        tick(); checkPins("rstwake.c1", 4'b0100, 4'b0000);
        rst_n = 1'b0;
        tick(); checkPins("rstwake.rst", 4'b0000, 4'b0000);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 8'd0);
        for (int c = 0; c < 3; c++) begin
            tick(); checkPins($sformatf("rstwake.after%0d", c), 4'b0000, 4'b0000);
        end

`ifdef CG_AUTO_IDLE_EN
        // Auto-idle: ON for 5 cycles, then IDLE. A busy pulse wakes it again,
        // and force_on holds it in ON.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 8'd5);
        tick(); tick(); tick();
        checkPins("idle.on", 4'b0010, 4'b0010);
        tick(); tick(); tick(); tick();
        checkPins("idle.c7", 4'b0010, 4'b0010);
        tick(); checkPins("idle.gated", 4'b0000, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 8'd5);
        tick(); checkPins("idle.rewake", 4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 8'd5);
        tick(); checkPins("idle.rewake2", 4'b0010, 4'b0000);
        tick(); checkPins("idle.reack", 4'b0010, 4'b0010);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 8'd5);
        for (int c = 0; c < 10; c++) begin
            tick(); checkPins($sformatf("idle.force%0d", c), 4'b0010, 4'b0010);
        end
`else
        // Without auto-idle, a long not-busy stretch and busy toggling change nothing.
        doReset();
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 8'd5);
        tick(); tick(); tick();
        checkPins("noidle.on", 4'b0001, 4'b0001);
        for (int c = 0; c < 8; c++) begin
            tick(); checkPins($sformatf("noidle.quiet%0d", c), 4'b0001, 4'b0001);
        end
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b0001, 4'b0000, (c % 2 == 0) ? 4'b1111 : 4'b0000, 8'd5);
            tick(); checkPins($sformatf("noidle.toggle%0d", c), 4'b0001, 4'b0001);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of gated clock channels (1..16).
REQ-002 SHALL have parameter WAKE_CYCLES, default 2: cycles a channel spends in WAKE before acknowledging (1..15).
REQ-003 SHALL have parameter IDLE_W, default 8: width of the idle limit and idle counters.
REQ-004 SHALL have port clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_i  in  NUM_CH  per-channel clock request, level.
REQ-007 SHALL have port force_on_i  in  NUM_CH  per-channel override; keeps the clock on regardless of idle state.
REQ-008 SHALL have port busy_i  in  NUM_CH  per-channel activity / wake sense from the fabric.
REQ-009 SHALL have port idle_limit_i  in  IDLE_W  idle cycles before auto-gating; 0 disables auto-gating.
REQ-010 SHALL have port cg_en_o  out  NUM_CH  enable to each channel's clock gate cell.
REQ-011 SHALL have port ack_o  out  NUM_CH  channel clock running and stable.

Function
REQ-012 Per channel, SHALL implement the FSM states OFF, WAKE, ON, IDLE.
REQ-013 Outputs SHALL be decoded from the state register only: cg_en_o = WAKE|ON; ack_o = ON; no combinational input-to-output path.
REQ-014 OFF -> WAKE SHALL occur only when (req_i|force_on_i) is high and the channel holds the wake grant.
REQ-015 At most one channel SHALL be in WAKE in any cycle.
REQ-016 The wake grant SHALL be round-robin, starting after the last granted channel; after reset, channel 0 has highest priority.
REQ-017 WAKE SHALL last exactly WAKE_CYCLES cycles, then enter ON; ack_o rises WAKE_CYCLES+1 cycles after grant.
REQ-018 Dropping req_i and force_on_i during WAKE SHALL NOT abort it; the channel completes to ON, then applies REQ-019.
REQ-019 ON -> OFF SHALL occur in the cycle after req_i and force_on_i are both low.
REQ-020 IDLE -> WAKE SHALL require busy_i|force_on_i high plus the wake grant; IDLE -> OFF occurs when req_i and force_on_i are both low.
REQ-021 If several channels request in the same cycle, ungranted channels SHALL stay in OFF/IDLE with cg_en_o low until granted.

Reset
REQ-022 With rst_n low at a clock edge, all channels SHALL enter OFF and all counters SHALL clear; cg_en_o=0, ack_o=0 from the next cycle.
REQ-023 Reset asserted mid-WAKE or mid-idle-count SHALL abandon the operation with no further output pulses.

Configuration
REQ-024 Macro CG_AUTO_IDLE_EN defined: in ON with force_on_i low and idle_limit_i nonzero, a per-channel counter SHALL count consecutive cycles with busy_i low.
REQ-025 The counter SHALL clear on any busy_i high, and SHALL saturate at its maximum value.
REQ-026 When the count reaches idle_limit_i, the channel SHALL go ON -> IDLE.
REQ-027 Macro CG_AUTO_IDLE_EN undefined: the IDLE state and the idle counters SHALL not be built, and busy_i and idle_limit_i SHALL be ignored.

Structure
REQ-028 The state enum, wake-grant index type and WAKE_CYCLES counter width SHALL live in shared package clk_gate_pkg.
REQ-029 The per-channel FSM and idle counter SHALL be sub-module clk_gate_ch.
REQ-030 The top level SHALL instantiate NUM_CH clk_gate_ch and one round-robin wake arbiter.
REQ-031 cg_en_o SHALL connect directly to the gate cell en pins.

Verification
REQ-032 Reset then req_i=4'b0001 -> cg_en_o[0] high 1 cycle later, ack_o[0] high 3 cycles after req (WAKE_CYCLES=2).
REQ-033 req_i=4'b1111 in one cycle -> channels wake in order 0,1,2,3, never two cg_en_o bits newly rising in overlapping WAKE windows; all ack by cycle 12.
REQ-034 Channel 0 ON, req_i[0] dropped -> cg_en_o[0] and ack_o[0] low the next cycle; req_i dropped mid-WAKE -> ON reached, then OFF.
REQ-035 CG_AUTO_IDLE_EN on, idle_limit_i=5, req_i[1]=1, busy_i[1]=0 -> IDLE after 5 ON cycles; busy_i[1] pulse -> ack again after 3 cycles; force_on_i[1]=1 blocks IDLE.
REQ-036 rst_n low during WAKE of channel 2 -> all outputs 0 next cycle; CG_AUTO_IDLE_EN off -> busy_i toggling has no effect.
